// File: rtl/degamma_inv_lut.sv
// -----------------------------------------------------------------------------
// degamma_inv_lut
//
// Inverse-gamma lookup for the ISP gamma path. A gamma-encoded pixel is mapped
// to the linear code i whose table entry T[i] is the largest one not exceeding
// the pixel. The table is written at run time so a single instance serves any
// monotonic gamma curve.
//
// The lookup is a binary search unrolled into DOUT_W pipeline stages, one per
// output bit (MSB first). One pixel is accepted per clock and the sync flags
// travel through a shift chain of the same depth.
//
// Flow control: there is no backpressure. A pixel is transferred on every rising
// edge where I_valid=1 and appears on O_valid exactly DOUT_W clocks later.
// Cycles with I_valid=0 travel through the pipe as bubbles.
//
// Ports
//   I_clk, I_rst_n    clock, synchronous active-low reset
//   I_tab_wr_en       table write strobe
//   I_tab_wr_addr     table write address (DOUT_W bits)
//   I_tab_wr_data     table write data (DIN_W bits)
//   I_valid/I_vs/I_hs pixel valid, frame sync, line sync
//   I_data            gamma-encoded pixel (DIN_W bits)
//   O_valid/O_vs/O_hs delayed valid and syncs
//   O_data            linear pixel (DOUT_W bits), 0 when invalid or not ready
//   O_tab_ready       set after the last table entry has been written
//   O_tab_err         sticky: an entry was written smaller than its predecessor
// -----------------------------------------------------------------------------
module degamma_inv_lut #(
    parameter int DIN_W  = 12,
    parameter int DOUT_W = 8
) (
    input  logic              I_clk,
    input  logic              I_rst_n,
    input  logic              I_tab_wr_en,
    input  logic [DOUT_W-1:0] I_tab_wr_addr,
    input  logic [DIN_W-1:0]  I_tab_wr_data,
    input  logic              I_valid,
    input  logic              I_vs,
    input  logic              I_hs,
    input  logic [DIN_W-1:0]  I_data,
    output logic              O_valid,
    output logic              O_vs,
    output logic              O_hs,
    output logic [DOUT_W-1:0] O_data,
    output logic              O_tab_ready,
    output logic              O_tab_err
);

    localparam int DEPTH = 1 << DOUT_W;

    // Lookup table and its status flags
    logic [DIN_W-1:0]  tab_q [DEPTH];
    logic [DIN_W-1:0]  tab_d [DEPTH];
    logic              tab_ready_q, tab_ready_d;
    logic              tab_err_q, tab_err_d;
    logic [DOUT_W-1:0] prev_addr;

    // Search pipeline: r_q[s] is the partial result after stage s,
    // x_q[s] the pixel carried to stage s+1 (the last stage needs no copy).
    logic [DOUT_W-1:0] r_q [DOUT_W];
    logic [DOUT_W-1:0] r_d [DOUT_W];
    logic [DIN_W-1:0]  x_q [DOUT_W-1];
    logic [DIN_W-1:0]  x_d [DOUT_W-1];

    // Per-stage inputs, stage 0 is fed straight from the pixel port
    logic [DOUT_W-1:0] r_in [DOUT_W];
    logic [DIN_W-1:0]  x_in [DOUT_W];
    logic [DOUT_W-1:0] bit_mask;
    logic [DOUT_W-1:0] cand;

    // Valid and sync shift chains, same depth as the search
    logic [DOUT_W-1:0] valid_q, valid_d;
    logic [DOUT_W-1:0] vs_q, vs_d;
    logic [DOUT_W-1:0] hs_q, hs_d;

    // ------------------------------------------------------------------
    // Table write port and status flags
    // ------------------------------------------------------------------
    always_comb begin
        tab_d       = tab_q;
        tab_ready_d = tab_ready_q;
        tab_err_d   = tab_err_q;
        prev_addr   = I_tab_wr_addr - {{(DOUT_W-1){1'b0}}, 1'b1};
        if (I_tab_wr_en) begin
            tab_d[I_tab_wr_addr] = I_tab_wr_data;
            if (&I_tab_wr_addr) begin
                tab_ready_d = 1'b1;
            end
            // Compared against the predecessor as it stands before this edge;
            // address 0 has no predecessor.
            if ((|I_tab_wr_addr) && (I_tab_wr_data < tab_q[prev_addr])) begin
                tab_err_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Binary search: stage s decides output bit DOUT_W-1-s
    // ------------------------------------------------------------------
    always_comb begin
        r_in[0] = '0;
        x_in[0] = I_data;
        for (int s = 1; s < DOUT_W; s++) begin
            r_in[s] = r_q[s-1];
            x_in[s] = x_q[s-1];
        end

        bit_mask = '0;
        cand     = '0;
        for (int s = 0; s < DOUT_W; s++) begin
            bit_mask                = '0;
            bit_mask[DOUT_W-1-s]    = 1'b1;
            cand                    = r_in[s] | bit_mask;
            // Taking the candidate whenever T[cand] <= x makes equal
            // entries resolve to the highest index.
            r_d[s] = (tab_q[cand] <= x_in[s]) ? cand : r_in[s];
        end

        for (int s = 0; s < DOUT_W-1; s++) begin
            x_d[s] = x_in[s];
        end

        valid_d = {valid_q[DOUT_W-2:0], I_valid};
        vs_d    = {vs_q[DOUT_W-2:0], I_vs};
        hs_d    = {hs_q[DOUT_W-2:0], I_hs};
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tab_q[i] <= '0;
            end
            for (int s = 0; s < DOUT_W; s++) begin
                r_q[s] <= '0;
            end
            for (int s = 0; s < DOUT_W-1; s++) begin
                x_q[s] <= '0;
            end
            tab_ready_q <= 1'b0;
            tab_err_q   <= 1'b0;
            valid_q     <= '0;
            vs_q        <= '0;
            hs_q        <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                tab_q[i] <= tab_d[i];
            end
            for (int s = 0; s < DOUT_W; s++) begin
                r_q[s] <= r_d[s];
            end
            for (int s = 0; s < DOUT_W-1; s++) begin
                x_q[s] <= x_d[s];
            end
            tab_ready_q <= tab_ready_d;
            tab_err_q   <= tab_err_d;
            valid_q     <= valid_d;
            vs_q        <= vs_d;
            hs_q        <= hs_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: data is zeroed for bubbles and until the table is complete
    // ------------------------------------------------------------------
    assign O_valid     = valid_q[DOUT_W-1];
    assign O_vs        = vs_q[DOUT_W-1];
    assign O_hs        = hs_q[DOUT_W-1];
    assign O_data      = (valid_q[DOUT_W-1] && tab_ready_q) ? r_q[DOUT_W-1] : '0;
    assign O_tab_ready = tab_ready_q;
    assign O_tab_err   = tab_err_q;

endmodule

// File: tb/tb_degamma_inv_lut.sv
// -----------------------------------------------------------------------------
// tb_degamma_inv_lut
//
// Bench for degamma_inv_lut. Inputs are driven and outputs sampled on the
// falling clock edge. Every cycle the outputs are compared with the head of an
// expected queue that holds DOUT_W entries, so an entry pushed with a pixel
// comes due exactly DOUT_W cycles later. Expected lookups come from a table
// model searched by a plain linear scan.
// -----------------------------------------------------------------------------
module tb_degamma_inv_lut;

    localparam int DIN_W  = 12;
    localparam int DOUT_W = 8;
    localparam int DEPTH  = 256;

    // ------------------------------------------------------------------
    // Clock and DUT
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              tab_wr_en;
    logic [DOUT_W-1:0] tab_wr_addr;
    logic [DIN_W-1:0]  tab_wr_data;
    logic              in_valid, in_vs, in_hs;
    logic [DIN_W-1:0]  in_data;
    logic              out_valid, out_vs, out_hs;
    logic [DOUT_W-1:0] out_data;
    logic              out_tab_ready, out_tab_err;

    degamma_inv_lut #(.DIN_W(DIN_W), .DOUT_W(DOUT_W)) dut (
        .I_clk         (clk),
        .I_rst_n       (rst_n),
        .I_tab_wr_en   (tab_wr_en),
        .I_tab_wr_addr (tab_wr_addr),
        .I_tab_wr_data (tab_wr_data),
        .I_valid       (in_valid),
        .I_vs          (in_vs),
        .I_hs          (in_hs),
        .I_data        (in_data),
        .O_valid       (out_valid),
        .O_vs          (out_vs),
        .O_hs          (out_hs),
        .O_data        (out_data),
        .O_tab_ready   (out_tab_ready),
        .O_tab_err     (out_tab_err)
    );

    // ------------------------------------------------------------------
    // Scoreboard and reference model
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;
    int step_no  = 0;

    // {valid, vs, hs, ungated data}
    logic [10:0]      exp_q[$];
    logic [DIN_W-1:0] m_tab [DEPTH];
    logic             m_ready;
    logic             m_err;

    // Largest index whose entry does not exceed x; 0 when none does.
    function automatic logic [7:0] ref_lookup(input logic [DIN_W-1:0] x);
        logic [7:0] res;
        res = 8'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_tab[i] <= x) res = 8'(i);
        end
        return res;
    endfunction

    function automatic logic [DIN_W-1:0] gamma_entry(input int i);
        int g;
        if (i == 0)        g = 373;
        else if (i <= 128) g = 569 + ((i - 1) * 2574) / 127;
        else               g = 3143 + ((i - 128) * 949) / 127;
        return DIN_W'(g);
    endfunction

    task automatic check_outputs(input string tag);
        logic [10:0] e;
        logic [12:0] act;
        logic [12:0] expv;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s step %0d: expected queue empty", tag, step_no);
        end else begin
            e    = exp_q.pop_front();
            expv = {e[10:8], (e[10] && m_ready) ? e[7:0] : 8'd0, m_ready, m_err};
            act  = {out_valid, out_vs, out_hs, out_data, out_tab_ready, out_tab_err};
            if (act !== expv) begin
                n_errors++;
                $display("FAIL %s step %0d: got v=%0b vs=%0b hs=%0b data=%0d rdy=%0b err=%0b, expected v=%0b vs=%0b hs=%0b data=%0d rdy=%0b err=%0b",
                         tag, step_no, act[12], act[11], act[10], act[9:2], act[1], act[0],
                         expv[12], expv[11], expv[10], expv[9:2], expv[1], expv[0]);
            end
        end
    endtask

    task automatic check_bit(input string tag, input logic act, input logic expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s step %0d: got %0b, expected %0b", tag, step_no, act, expv);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks (called on a falling edge, return on the next one)
    // ------------------------------------------------------------------
    task automatic step(input string tag, input logic v, input logic vs, input logic hs,
                        input logic [DIN_W-1:0] x, input int exp_d,
                        input logic we, input logic [DOUT_W-1:0] wa, input logic [DIN_W-1:0] wd);
        logic [7:0] d;
        check_outputs(tag);
        in_valid    = v;
        in_vs       = vs;
        in_hs       = hs;
        in_data     = x;
        tab_wr_en   = we;
        tab_wr_addr = wa;
        tab_wr_data = wd;
        d = (exp_d < 0) ? ref_lookup(x) : 8'(exp_d);
        exp_q.push_back({v, vs, hs, v ? d : 8'd0});
        if (we) begin
            if (wa == 8'd255) m_ready = 1'b1;
            if (wa != 8'd0 && wd < m_tab[wa - 8'd1]) m_err = 1'b1;
            m_tab[wa] = wd;
        end
        @(negedge clk);
        step_no++;
    endtask

    task automatic pix(input string tag, input logic [DIN_W-1:0] x, input int exp_d);
        step(tag, 1'b1, 1'b0, 1'b0, x, exp_d, 1'b0, 8'd0, 12'd0);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b0, 12'd0, 0, 1'b0, 8'd0, 12'd0);
    endtask

    task automatic wr(input string tag, input logic [DOUT_W-1:0] a, input logic [DIN_W-1:0] d);
        step(tag, 1'b0, 1'b0, 1'b0, 12'd0, 0, 1'b1, a, d);
    endtask

    task automatic do_reset(input int cycles);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vs     = 1'b0;
        in_hs     = 1'b0;
        in_data   = '0;
        tab_wr_en = 1'b0;
        repeat (cycles) @(negedge clk);
        for (int i = 0; i < DEPTH; i++) m_tab[i] = '0;
        m_ready = 1'b0;
        m_err   = 1'b0;
        exp_q.delete();
        for (int i = 0; i < DOUT_W; i++) exp_q.push_back(11'd0);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [DIN_W-1:0]  x;
        logic [DOUT_W-1:0] e;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int lo;
        int x;
        logic [DIN_W-1:0] t;

        vecs[0] = '{x: 12'd373,  e: 8'd0};
        vecs[1] = '{x: 12'd568,  e: 8'd0};
        vecs[2] = '{x: 12'd569,  e: 8'd1};
        vecs[3] = '{x: 12'd3143, e: 8'd128};
        vecs[4] = '{x: 12'd3142, e: 8'd127};
        vecs[5] = '{x: 12'd4095, e: 8'd255};
        vecs[6] = '{x: 12'd100,  e: 8'd0};
        vecs[7] = '{x: 12'd4092, e: 8'd255};

        rst_n       = 1'b0;
        tab_wr_en   = 1'b0;
        tab_wr_addr = '0;
        tab_wr_data = '0;
        in_valid    = 1'b0;
        in_vs       = 1'b0;
        in_hs       = 1'b0;
        in_data     = '0;
        do_reset(2);

        // Table not loaded yet: pixel passes with data forced to 0
        pix("not_ready", 12'd2000, -1);
        idle("not_ready", DOUT_W + 1);
        check_bit("not_ready_flag", out_tab_ready, 1'b0);

        // Gamma-2.6 curve, then back-to-back boundary pixels
        for (int a = 0; a < DEPTH; a++) wr("load_gamma", 8'(a), gamma_entry(a));
        for (int i = 0; i < 8; i++) pix("gamma_vec", vecs[i].x, int'(vecs[i].e));
        idle("gamma_vec", DOUT_W);
        check_bit("gamma_ready", out_tab_ready, 1'b1);

        // Gapped valid with sync pulses
        step("gapped", 1'b1, 1'b1, 1'b0, 12'd1000, -1, 1'b0, 8'd0, 12'd0);
        step("gapped", 1'b0, 1'b0, 1'b0, 12'd0,    -1, 1'b0, 8'd0, 12'd0);
        step("gapped", 1'b1, 1'b0, 1'b1, 12'd2500, -1, 1'b0, 8'd0, 12'd0);
        step("gapped", 1'b1, 1'b0, 1'b0, 12'd600,  -1, 1'b0, 8'd0, 12'd0);
        step("gapped", 1'b0, 1'b0, 1'b0, 12'd0,    -1, 1'b0, 8'd0, 12'd0);
        idle("gapped", DOUT_W);

        // Random monotonic table with flat runs, random pixel stream
        lo = $urandom_range(0, 50);
        for (int a = 0; a < DEPTH; a++) begin
            lo = lo + ((a == 0) ? 0 : int'($urandom_range(0, 15)));
            wr("load_rand", 8'(a), DIN_W'(lo));
        end
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                t = m_tab[$urandom_range(0, DEPTH - 1)];
                x = int'(t) + int'($urandom_range(0, 2)) - 1;
                if (x < 0) x = 0;
                if (x > 4095) x = 4095;
            end else begin
                x = int'($urandom_range(0, 4095));
            end
            step("random", ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), DIN_W'(x), -1, 1'b0, 8'd0, 12'd0);
        end
        idle("random", DOUT_W);

        // Monotonicity violation is sticky
        do_reset(2);
        wr("err_seq", 8'd9, 12'd600);
        check_bit("err_clean", out_tab_err, 1'b0);
        wr("err_seq", 8'd10, 12'd500);
        wr("err_seq", 8'd11, 12'd700);
        wr("err_seq", 8'd12, 12'd800);
        idle("err_seq", 2);
        check_bit("err_sticky", out_tab_err, 1'b1);

        // Reset with five pixels in flight
        for (int i = 0; i < 5; i++) pix("in_flight", DIN_W'($urandom_range(0, 4095)), -1);
        do_reset(1);
        idle("after_reset", DOUT_W + 2);
        check_bit("reset_ready", out_tab_ready, 1'b0);
        check_bit("reset_err", out_tab_err, 1'b0);

        // Only the top entry written: the rest must read back as zero
        wr("zero_tab", 8'd255, 12'd4095);
        pix("zero_tab", 12'd0, 254);
        pix("zero_tab", 12'd4094, 254);
        pix("zero_tab", 12'd4095, 255);
        idle("zero_tab", DOUT_W);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/degamma_inv_lut.md
Name: degamma_inv_lut

Overview:
- Inverse-gamma (degamma) block for the ISP gamma path.
- Takes a 12-bit gamma-encoded pixel stream and returns the 8-bit linear code whose table entry is the largest one not exceeding the input.
- The 256-entry monotonic table is written at run time through a write port, so one block serves every gamma curve.
- The lookup is a fully pipelined binary search, one stage per output bit; it accepts one pixel per clock and carries sync signals along with the data.

Parameters:
- DIN_W, 12: width of the encoded input and of each table entry.
- DOUT_W, 8: width of the linear output. Table depth is 2^DOUT_W. Pipeline depth is DOUT_W stages.

Ports:
- I_clk  in  1  sole clock.
- I_rst_n  in  1  reset; synchronous and active-low.
- I_tab_wr_en  in  1  table write strobe.
- I_tab_wr_addr  in  DOUT_W  table write address.
- I_tab_wr_data  in  DIN_W  table write data.
- I_valid  in  1  input pixel valid.
- I_vs  in  1  frame sync, delayed alongside data.
- I_hs  in  1  line sync, delayed alongside data.
- I_data  in  DIN_W  gamma-encoded pixel.
- O_valid  out  1  output pixel valid.
- O_vs  out  1  delayed I_vs.
- O_hs  out  1  delayed I_hs.
- O_data  out  DOUT_W  linear pixel.
- O_tab_ready  out  1  set once the last table entry has been written.
- O_tab_err  out  1  sticky monotonicity-violation flag.

Behaviour:
- Reset (I_rst_n low at a rising edge):
  - All table entries become 0.
  - All pipeline registers clear.
  - O_valid, O_vs, O_hs, O_data, O_tab_ready and O_tab_err all become 0.
  - Reset mid-frame discards every in-flight pixel. There is no output pulse for discarded pixels.
- Table write:
  - On an edge with I_tab_wr_en=1, T[I_tab_wr_addr] <= I_tab_wr_data. The new value is visible to search stages from the next cycle.
  - O_tab_ready is set on the cycle after a write to address 2^DOUT_W-1. It stays set until reset.
  - O_tab_err is set (sticky until reset) when a write to address a>0 carries data < T[a-1] as held at that edge. Writes to address 0 never flag.
  - The table is loaded in ascending address order.
  - Writes while pixels are in flight are legal. Only the data values of in-flight pixels become unspecified; valid/sync timing is unaffected.
- Search (b = DOUT_W-1 down to 0; stage k handles bit b = DOUT_W-k):
  - Each stage holds partial result r and pixel x.
  - cand = r | (1<<b). The stage registers r' = cand if T[cand] <= x, else r.
  - Stage 1 uses I_data with r=0. Comparisons are unsigned.
  - Result: the largest i with T[i] <= x.
  - If x < T[1], the result is 0, including when x < T[0] (no underflow indication).
  - x at or above T[255] gives 255.
- Latency:
  - Exactly DOUT_W cycles from the I_valid edge to the O_valid edge.
  - I_vs, I_hs and I_valid pass through an identical DOUT_W-deep shift chain.
  - Throughput is one pixel per clock with no backpressure. Bubbles (I_valid=0) propagate as bubbles.
- Output gating:
  - When O_valid=0, O_data holds 0.
  - While O_tab_ready=0, O_data is forced to 0 even when O_valid=1. Valid/sync timing is unchanged.
- Duplicate entries (flat curve): the highest matching index wins.

Test Plan:
- Reset release, no writes, I_valid=1, I_data=2000 → after 8 cycles O_valid=1, O_data=0 (table not ready). O_tab_ready=0, O_tab_err=0.
- Load gamma-2.6 curve (T[0]=373, T[1]=569, T[128]=3143, T[255]=4092) ascending; then stream x = 373, 568, 569, 3143, 3142, 4095 back-to-back → O_data = 0, 0, 1, 128, 127, 255 on consecutive cycles starting 8 cycles after the first input. O_tab_ready=1.
- Stream x=100 (below T[0]) → O_data=0. Stream x=4092 → 255.
- Gapped I_valid pattern 1,0,1,1,0 with I_vs pulse on the first pixel and I_hs on the third → O_valid 1,0,1,1,0 and matching O_vs/O_hs pulses, each exactly 8 cycles later.
- Write T[10]=500 after T[9]=600 → O_tab_err=1 next cycle and remains 1 through later valid writes; cleared only by reset.
- Assert I_rst_n=0 for one cycle while 5 pixels are in flight → no O_valid pulses afterwards, table all-zero, O_tab_ready=0.
